// File: rtl/trace_arbiter_if.sv
// Trace-source bundle between the capture sources and the trace arbiter.
// The master drives the samples; the slave returns the merged stream and drop statistics.
interface trace_arbiter_if #(
    parameter int NS   = 5,
    parameter int TW   = 32,
    parameter int CNTw = 8,
    parameter int SRCw = (NS > 1) ? $clog2(NS) : 1
);
    logic                 enable;
    logic [NS-1:0]        trigger_in;
    logic [NS*TW-1:0]     trace_in;
    logic                 trigger_out;
    logic [TW-1:0]        trace_out;
    logic [SRCw-1:0]      src_out;
    logic [NS*CNTw-1:0]   drop_cnt_all;
    logic                 drop_any;

    modport master (
        output enable, trigger_in, trace_in,
        input  trigger_out, trace_out, src_out, drop_cnt_all, drop_any
    );

    modport slave (
        input  enable, trigger_in, trace_in,
        output trigger_out, trace_out, src_out, drop_cnt_all, drop_any
    );
endinterface

// File: rtl/trace_arbiter.sv
// Round-robin merge of NS trace sources into the single trace buffer write port.
// Each source owns a small FIFO; overflowing samples are counted per source.
module trace_arbiter #(
    parameter int NS    = 5,
    parameter int TW    = 32,
    parameter int DEPTH = 4,
    parameter int CNTw  = 8
) (
    input  logic           clk,
    input  logic           reset,
    trace_arbiter_if.slave tif
);
    localparam int SRCw = (NS > 1) ? $clog2(NS) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int DW   = SRCw + 1;

    logic [TW-1:0]   mem_r      [NS][DEPTH];
    logic [AW-1:0]   wr_ptr_r   [NS];
    logic [AW-1:0]   rd_ptr_r   [NS];
    logic [CW-1:0]   count_r    [NS];
    logic [CNTw-1:0] drop_cnt_r [NS];
    logic [SRCw-1:0] last_grant_r;
    logic            trigger_out_r;
    logic [TW-1:0]   trace_out_r;
    logic [SRCw-1:0] src_out_r;
    logic            drop_any_r;

    logic [NS-1:0]   req_s;
    logic [NS-1:0]   full_s;
    logic [NS-1:0]   pop_s;
    logic [NS-1:0]   push_s;
    logic [NS-1:0]   drop_s;
    logic [CNTw-1:0] drop_cnt_nxt_s [NS];
    logic            drop_any_nxt_s;
    logic            grant_valid_s;
    logic [SRCw-1:0] grant_idx_s;
    logic [DW-1:0]   dist_s;
    logic [DW-1:0]   best_s;
    logic [TW-1:0]   head_s;

    // Rotating priority: the requester closest after last_grant wins; last_grant itself ranks last.
    always_comb begin
        req_s         = '0;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        best_s        = DW'(NS + 1);
        dist_s        = '0;
        for (int i = 0; i < NS; i++) begin
            req_s[i] = (count_r[i] != CW'(0));
            if (SRCw'(i) > last_grant_r) begin
                dist_s = DW'(i) - {1'b0, last_grant_r};
            end else begin
                dist_s = DW'(i + NS) - {1'b0, last_grant_r};
            end
            if (req_s[i] && (dist_s < best_s)) begin
                best_s        = dist_s;
                grant_valid_s = 1'b1;
                grant_idx_s   = SRCw'(i);
            end else begin
                best_s        = best_s;
            end
        end
    end

    // Per-source push/pop/drop decisions; a full FIFO popped this cycle still accepts a push.
    always_comb begin
        full_s         = '0;
        pop_s          = '0;
        push_s         = '0;
        drop_s         = '0;
        head_s         = '0;
        drop_any_nxt_s = 1'b0;
        for (int i = 0; i < NS; i++) begin
            full_s[i] = (count_r[i] == CW'(DEPTH));
            pop_s[i]  = grant_valid_s && (grant_idx_s == SRCw'(i));
            push_s[i] = tif.enable && tif.trigger_in[i] && (!full_s[i] || pop_s[i]);
            drop_s[i] = tif.enable && tif.trigger_in[i] && full_s[i] && !pop_s[i];
            if (drop_s[i] && (drop_cnt_r[i] != {CNTw{1'b1}})) begin
                drop_cnt_nxt_s[i] = drop_cnt_r[i] + CNTw'(1);
            end else begin
                drop_cnt_nxt_s[i] = drop_cnt_r[i];
            end
            if (pop_s[i]) begin
                head_s = mem_r[i][rd_ptr_r[i]];
            end else begin
                head_s = head_s;
            end
            drop_any_nxt_s = drop_any_nxt_s | (drop_cnt_nxt_s[i] != CNTw'(0));
        end
    end

    // FIFO state, drop counters and the output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NS; i++) begin
                wr_ptr_r[i]   <= '0;
                rd_ptr_r[i]   <= '0;
                count_r[i]    <= '0;
                drop_cnt_r[i] <= '0;
            end
            last_grant_r  <= SRCw'(NS - 1);
            trigger_out_r <= 1'b0;
            trace_out_r   <= '0;
            src_out_r     <= '0;
            drop_any_r    <= 1'b0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (push_s[i]) begin
                    mem_r[i][wr_ptr_r[i]] <= tif.trace_in[i*TW +: TW];
                    wr_ptr_r[i]           <= wr_ptr_r[i] + AW'(1);
                end else begin
                    wr_ptr_r[i]           <= wr_ptr_r[i];
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
                end else begin
                    rd_ptr_r[i] <= rd_ptr_r[i];
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CW'(1);
                    2'b01:   count_r[i] <= count_r[i] - CW'(1);
                    default: count_r[i] <= count_r[i];
                endcase
                drop_cnt_r[i] <= drop_cnt_nxt_s[i];
            end
            drop_any_r    <= drop_any_nxt_s;
            trigger_out_r <= grant_valid_s;
            if (grant_valid_s) begin
                trace_out_r  <= head_s;
                src_out_r    <= grant_idx_s;
                last_grant_r <= grant_idx_s;
            end else begin
                trace_out_r  <= trace_out_r;
                src_out_r    <= src_out_r;
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign tif.trigger_out = trigger_out_r;
    assign tif.trace_out   = trace_out_r;
    assign tif.src_out     = src_out_r;
    assign tif.drop_any    = drop_any_r;

    for (genvar g = 0; g < NS; g++) begin : g_drop_pack
        assign tif.drop_cnt_all[g*CNTw +: CNTw] = drop_cnt_r[g];
    end
endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: reset, burst ordering, overflow, full+pop, saturation, enable and reset.
module tb_trace_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    trace_arbiter_if tif ();

    trace_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .tif   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        tif.trace_in[i*32 +: 32] = w;
    endtask

    function automatic logic [7:0] dc(input int i);
        return tif.drop_cnt_all[i*8 +: 8];
    endfunction

    task automatic expect_out(input string tag, input logic [2:0] src, input logic [31:0] data);
        check({tag, "_valid"}, 64'(tif.trigger_out), 64'd1);
        check({tag, "_src"},   64'(tif.src_out),     64'(src));
        check({tag, "_data"},  64'(tif.trace_out),   64'(data));
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        tif.enable     = 1'b0;
        tif.trigger_in = 5'b00000;
        tif.trace_in   = '0;
        tick();
        tick();
        check("rst_trigger_out", 64'(tif.trigger_out),  64'd0);
        check("rst_trace_out",   64'(tif.trace_out),    64'd0);
        check("rst_src_out",     64'(tif.src_out),      64'd0);
        check("rst_drop_any",    64'(tif.drop_any),     64'd0);
        check("rst_drop_cnt",    64'(tif.drop_cnt_all), 64'd0);
        reset      = 1'b1;
        tif.enable = 1'b1;
        tick();

        // Coincident burst: all five sources at once, drained 0..4.
        for (int i = 0; i < 5; i++) set_word(i, 32'h10 + 32'(i));
        tif.trigger_in = 5'b11111;
        tick();
        tif.trigger_in = 5'b00000;
        check("burst_latency", 64'(tif.trigger_out), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("burst%0d", i), 3'(i), 32'h10 + 32'(i));
        end
        tick();
        check("burst_end", 64'(tif.trigger_out), 64'd0);
        check("burst_nodrop", 64'(tif.drop_any), 64'd0);

        // Single source 2.
        set_word(2, 32'hA5A5_0002);
        tif.trigger_in = 5'b00100;
        tick();
        tif.trigger_in = 5'b00000;
        check("single_latency", 64'(tif.trigger_out), 64'd0);
        tick();
        expect_out("single", 3'd2, 32'hA5A5_0002);
        tick();
        check("single_pulse", 64'(tif.trigger_out), 64'd0);
        check("single_hold_data", 64'(tif.trace_out), 64'h0000_0000_A5A5_0002);
        check("single_hold_src", 64'(tif.src_out), 64'd2);
        check("single_nodrop", 64'(tif.drop_cnt_all), 64'd0);

        // Overflow: sources 0 and 3 every cycle for 20 cycles.
        tif.trigger_in = 5'b01001;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e >= 2) begin
                check($sformatf("ovf_valid_e%0d", e), 64'(tif.trigger_out), 64'd1);
                check($sformatf("ovf_src_e%0d", e), 64'(tif.src_out), (e % 2 == 0) ? 64'd3 : 64'd0);
            end else begin
                check("ovf_first_idle", 64'(tif.trigger_out), 64'd0);
            end
            if (e == 7) check("ovf_drop_any_pre", 64'(tif.drop_any), 64'd0);
            if (e == 8) check("ovf_drop_any_first", 64'(tif.drop_any), 64'd1);
        end
        tif.trigger_in = 5'b00000;
        for (int e = 0; e < 10; e++) tick();
        check("ovf_drop0", 64'(dc(0)), 64'd7);
        check("ovf_drop3", 64'(dc(3)), 64'd6);
        check("ovf_drop_any", 64'(tif.drop_any), 64'd1);
        check("ovf_drained", 64'(tif.trigger_out), 64'd0);

        // Full + pop: FIFO 1 fills behind three one-shot competitors, then drains 1/cycle while pushing.
        for (int i = 0; i < 5; i++) set_word(i, 32'hD0 + 32'(i));
        set_word(1, 32'h101);
        tif.trigger_in = 5'b11011;
        tick();
        tif.trigger_in = 5'b00010;
        for (int n = 2; n <= 11; n++) begin
            set_word(1, 32'h100 + 32'(n));
            tick();
            case (n)
                2:       expect_out("fp_c2", 3'd4, 32'hD4);
                3:       expect_out("fp_c3", 3'd0, 32'hD0);
                4:       expect_out("fp_c4", 3'd1, 32'h101);
                5:       expect_out("fp_c5", 3'd3, 32'hD3);
                default: expect_out($sformatf("fp_c%0d", n), 3'd1, 32'h100 + 32'(n - 4));
            endcase
        end
        tif.trigger_in = 5'b00000;
        for (int n = 12; n <= 15; n++) begin
            tick();
            expect_out($sformatf("fp_c%0d", n), 3'd1, 32'h100 + 32'(n - 4));
        end
        tick();
        check("fp_end", 64'(tif.trigger_out), 64'd0);
        check("fp_drop1", 64'(dc(1)), 64'd0);

        // Saturation: sources 0 and 4 compete for 700 cycles.
        tif.trigger_in = 5'b10001;
        for (int e = 0; e < 700; e++) tick();
        tif.trigger_in = 5'b00000;
        for (int e = 0; e < 12; e++) tick();
        check("sat_drop4", 64'(dc(4)), 64'd255);
        check("sat_drop0", 64'(dc(0)), 64'd255);
        check("sat_idle", 64'(tif.trigger_out), 64'd0);

        // Enable low: triggers neither pushed nor counted.
        tif.enable     = 1'b0;
        tif.trigger_in = 5'b11111;
        for (int e = 0; e < 5; e++) tick();
        check("en_no_output", 64'(tif.trigger_out), 64'd0);
        tif.trigger_in = 5'b00000;
        tick();
        check("en_no_output_late", 64'(tif.trigger_out), 64'd0);
        check("en_counters", 64'(tif.drop_cnt_all), 64'h00FF_0600_00FF);

        // Reset with three queued samples.
        tif.enable     = 1'b1;
        tif.trigger_in = 5'b01110;
        tick();
        tif.trigger_in = 5'b00000;
        reset          = 1'b0;
        tick();
        reset          = 1'b1;
        check("rr_trigger_out", 64'(tif.trigger_out),  64'd0);
        check("rr_trace_out",   64'(tif.trace_out),    64'd0);
        check("rr_src_out",     64'(tif.src_out),      64'd0);
        check("rr_drop_any",    64'(tif.drop_any),     64'd0);
        check("rr_drop_cnt",    64'(tif.drop_cnt_all), 64'd0);
        for (int e = 0; e < 3; e++) begin
            tick();
            check($sformatf("rr_empty%0d", e), 64'(tif.trigger_out), 64'd0);
        end
        set_word(0, 32'hC0);
        set_word(4, 32'hC4);
        tif.trigger_in = 5'b10001;
        tick();
        tif.trigger_in = 5'b00000;
        tick();
        expect_out("rr_first", 3'd0, 32'hC0);
        tick();
        expect_out("rr_second", 3'd4, 32'hC4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trace_arbiter.md
Name: trace_arbiter

Overview:
- Shares the single trace buffer write port between all trace sources in the MPSoC: the four mor1k tiles and the NoC.
- Replaces the fixed-priority trigger mux, which starves low-priority sources and loses coincident samples.
- Each source gets a small FIFO; a round-robin arbiter drains one sample per cycle into the trace buffer and tags it with its source index.
- Samples that arrive while a source FIFO is full are counted per source.

Parameters:
- NS, 5, number of trace sources (index 0..3 = tiles, 4 = NoC).
- TW, 32, trace word width (matches trace buffer Fpay).
- DEPTH, 4, entries per source FIFO; must be a power of two, >=2.
- CNTw, 8, width of each per-source drop counter.
- SRCw, derived log2(NS) (3 for NS=5), width of the source tag.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-low reset.
- enable, in, 1, capture enable; 0 = ignore triggers, keep draining.
- trigger_in, in, NS, per-source sample valid.
- trace_in, in, NS*TW, per-source sample; source i occupies [(i+1)*TW-1 : i*TW].
- trigger_out, out, 1, write enable to trace buffer.
- trace_out, out, TW, sample to trace buffer.
- src_out, out, SRCw, index of the source of trace_out.
- drop_cnt_all, out, NS*CNTw, per-source saturating drop counters, same slicing as trace_in.
- drop_any, out, 1, OR of (drop_cnt != 0) over all sources.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All FIFOs empty; all drop counters 0.
  - trigger_out=0, trace_out=0, src_out=0, drop_any=0.
  - last_grant=NS-1, so source 0 has first priority.
  - Reset mid-operation discards all queued samples; no partial output is emitted afterwards.
- Push:
  - Push into FIFO i happens when enable && trigger_in[i] && (count_i<DEPTH || pop_i).
  - A full FIFO popped in the same cycle accepts the push.
  - Count updates: push+pop leaves count unchanged; push only +1; pop only -1.
- Drop:
  - enable && trigger_in[i] && full_i && !pop_i increments drop_cnt[i].
  - The counter saturates at 2^CNTw-1; no wrap.
  - When enable==0, triggers are neither pushed nor counted.
- Arbitration (combinational, from registered FIFO state):
  - Requesters are the non-empty FIFOs.
  - Grant goes to the first requester at index (last_grant+1) mod NS, (last_grant+2) mod NS, and so on.
  - At most one pop per cycle. last_grant updates only when a grant occurs.
  - With no requesters, last_grant holds.
- Output register:
  - On a grant: trigger_out=1, trace_out=head of the granted FIFO, src_out=granted index, all valid on the next cycle.
  - With no grant: trigger_out=0; trace_out and src_out hold their last value.
  - trigger_out is a single-cycle pulse per sample.
- Latency: a sample sampled at edge t (trigger_in high in the preceding cycle) can appear on trigger_out/trace_out no earlier than the cycle after edge t+1, i.e. 2 clk edges. There is no back-pressure from the trace buffer.
- Ordering: per-source FIFO order is preserved. Across sources, sample order follows round-robin order only.
- Throughput: 1 sample/cycle aggregate. A single source triggering every cycle never drops.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by the count register (width log2(DEPTH)+1).
- drop_any is registered and updates in the same cycle as the counters.

Test Plan:
- Single source: enable=1, trigger_in=5'b00100 for one cycle with trace word 0xA5A5_0002 -> two edges later trigger_out=1 for exactly one cycle, trace_out=0xA5A5_0002, src_out=2; drop_cnt all 0.
- Coincident burst: all 5 triggers high for one cycle with data 0x10+i -> five consecutive trigger_out pulses with src_out 0,1,2,3,4 and data 0x10..0x14; no drops.
- Overflow: source 3 and source 0 both trigger continuously for 20 cycles, DEPTH=4 -> output alternates src 0/3. From first full onward, each source loses about half its pushes: drop_cnt[3] and drop_cnt[0] >0 and equal ±1; drop_any=1.
- Full + pop same cycle: fill FIFO 1 to 4 entries with enable low to others, keep trigger_in[1] high -> every push accepted (the FIFO drains 1/cycle); drop_cnt[1] stays 0.
- Saturation: CNTw=8, source 4's FIFO held full by competing traffic with 300 drop events -> drop_cnt[4]=255, no wrap.
- Enable/reset: enable=0 while triggering -> no output, no drop counts. Assert reset low for one edge with 3 entries queued -> all outputs 0, FIFOs empty, next grant is source 0.
